// File: rtl/prog_loader_if.sv
// Program byte stream into prog_loader: restart request, valid/data/last, and the ready response.
interface prog_loader_if;
    logic       load_start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (output load_start, in_valid, in_data, in_last, input in_ready);
    modport slave  (input load_start, in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Streams a program into instruction memory and holds the CPU in reset until the load completes.
// Optional PROG_LOADER_CHECKSUM_EN adds a trailing modulo-256 checksum byte verified in a CHECK state.
module prog_loader #(
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk50,
    input  logic                     reset,
    prog_loader_if.slave             bus,
    input  logic [7:0]               read_addr,
    output logic [7:0]               instruction,
    output logic                     cpu_reset,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     load_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        ERR   = 3'd3
`ifdef PROG_LOADER_CHECKSUM_EN
        ,CHECK = 3'd4
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   ptr;
    logic [7:0]      mem [DEPTH];
    logic            xfer;
    logic            load_xfer;
    logic            last_slot;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
    logic            check_xfer;
`endif

    assign xfer      = bus.in_valid & bus.in_ready;
    assign load_xfer = xfer & (state == LOAD) & ~bus.load_start;
    assign last_slot = (ptr == AW'(DEPTH - 1));
`ifdef PROG_LOADER_CHECKSUM_EN
    assign check_xfer = xfer & (state == CHECK) & ~bus.load_start;
`endif

    // State register
    always_ff @(posedge clk50) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; a restart request outranks any transfer in flight
    always_comb begin
        state_nxt = state;
        if (bus.load_start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD: begin
                    if (xfer) begin
                        if (bus.in_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            state_nxt = CHECK;
`else
                            state_nxt = RUN;
`endif
                        end else if (last_slot) begin
                            state_nxt = ERR;
                        end
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (xfer) state_nxt = (bus.in_data == csum) ? RUN : ERR;
                end
`endif
                default: state_nxt = state;
            endcase
        end
    end

    // Moore outputs decoded from the state register
    always_comb begin
        bus.in_ready = 1'b0;
        cpu_reset    = 1'b1;
        case (state)
            LOAD:    bus.in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHECK:   bus.in_ready = 1'b1;
`endif
            RUN:     cpu_reset    = reset;
            default: bus.in_ready = 1'b0;
        endcase
    end

    // Load bookkeeping: write pointer, stored byte count, sticky error
    always_ff @(posedge clk50) begin
        if (reset || bus.load_start) begin
            ptr        <= '0;
            word_count <= '0;
            load_err   <= 1'b0;
        end else if (load_xfer) begin
            ptr        <= ptr + AW'(1);
            word_count <= word_count + CW'(1);
            if (!bus.in_last && last_slot) load_err <= 1'b1;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        else if (check_xfer && (bus.in_data != csum)) begin
            load_err <= 1'b1;
        end
`endif
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Running modulo-256 sum of stored program bytes
    always_ff @(posedge clk50) begin
        if (reset || bus.load_start) csum <= 8'h00;
        else if (load_xfer)          csum <= csum + bus.in_data;
    end
`endif

    // Instruction memory survives reset and restarts
    always_ff @(posedge clk50) begin
        if (!reset && load_xfer) mem[ptr] <= bus.in_data;
    end

    always_comb begin
        instruction = 8'h00;
        if ({1'b0, read_addr} < 9'(DEPTH)) instruction = mem[read_addr[AW-1:0]];
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (DEPTH=32); define PROG_LOADER_CHECKSUM_EN to cover the checksum build.
module tb_prog_loader;

    logic       clk50 = 1'b0;
    logic       reset;
    logic [7:0] read_addr;
    logic [7:0] instruction;
    logic       cpu_reset;
    logic [5:0] word_count;
    logic       load_err;
    int         n_checks = 0;
    int         n_fail   = 0;

    prog_loader_if bus();

    prog_loader #(.DEPTH(32)) dut (
        .clk50       (clk50),
        .reset       (reset),
        .bus         (bus),
        .read_addr   (read_addr),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .word_count  (word_count),
        .load_err    (load_err)
    );

    always #10 clk50 = ~clk50;

    task automatic tick;
        @(posedge clk50);
        #1;
    endtask

    task automatic start_load;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_reset_held: got %b want 1", cpu_reset); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (word_count !== 6'd0) begin n_fail++; $display("FAIL rst_word_count: got %0d want 0", word_count); end
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL rst_load_err: got %b want 0", load_err); end
        reset = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b0 || word_count !== 6'd0) begin n_fail++; $display("FAIL idle_ignores_valid: ready %b count %0d want 0 0", bus.in_ready, word_count); end
        n_checks++; if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL idle_cpu_reset: got %b want 1", cpu_reset); end
    endtask

    task automatic test_basic_load;
        logic [7:0] prog [6];
        prog = '{8'h49, 8'hC1, 8'h60, 8'hA9, 8'h4D, 8'hC3};
        start_load();
        n_checks++; if (bus.in_ready !== 1'b1 || word_count !== 6'd0) begin n_fail++; $display("FAIL load_entry: ready %b count %0d want 1 0", bus.in_ready, word_count); end
        for (int i = 0; i < 5; i++) send(prog[i], 1'b0);
        n_checks++; if (cpu_reset !== 1'b1 || word_count !== 6'd5) begin n_fail++; $display("FAIL mid_load: cpu_reset %b count %0d want 1 5", cpu_reset, word_count); end
        send(prog[5], 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
        n_checks++; if (cpu_reset !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL check_wait: cpu_reset %b ready %b want 1 1", cpu_reset, bus.in_ready); end
        send(8'h23, 1'b0);
`endif
        n_checks++; if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL run_cpu_reset: got %b want 0", cpu_reset); end
        n_checks++; if (word_count !== 6'd6) begin n_fail++; $display("FAIL run_word_count: got %0d want 6", word_count); end
        n_checks++; if (bus.in_ready !== 1'b0 || load_err !== 1'b0) begin n_fail++; $display("FAIL run_flags: ready %b err %b want 0 0", bus.in_ready, load_err); end
        read_addr = 8'd3; #1;
        n_checks++; if (instruction !== 8'hA9) begin n_fail++; $display("FAIL read_addr3: got %h want a9", instruction); end
        read_addr = 8'd5; #1;
        n_checks++; if (instruction !== 8'hC3) begin n_fail++; $display("FAIL read_addr5: got %h want c3", instruction); end
        read_addr = 8'd40; #1;
        n_checks++; if (instruction !== 8'h00) begin n_fail++; $display("FAIL read_oob40: got %h want 00", instruction); end
        read_addr = 8'd255; #1;
        n_checks++; if (instruction !== 8'h00) begin n_fail++; $display("FAIL read_oob255: got %h want 00", instruction); end
        send(8'hEE, 1'b1);
        read_addr = 8'd0; #1;
        n_checks++; if (word_count !== 6'd6 || cpu_reset !== 1'b0 || instruction !== 8'h49) begin n_fail++; $display("FAIL run_ignores_valid: count %0d cpu_reset %b mem0 %h want 6 0 49", word_count, cpu_reset, instruction); end
    endtask

    task automatic test_overflow;
        start_load();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h80;
        bus.in_last  = 1'b0;
        read_addr    = 8'd0;
        #1;
        n_checks++; if (instruction !== 8'h49) begin n_fail++; $display("FAIL rdw_before_edge: got %h want 49", instruction); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (instruction !== 8'h80) begin n_fail++; $display("FAIL rdw_after_edge: got %h want 80", instruction); end
        for (int i = 1; i < 31; i++) send(8'(8'h80 + i), 1'b0);
        n_checks++; if (load_err !== 1'b0 || bus.in_ready !== 1'b1 || word_count !== 6'd31) begin n_fail++; $display("FAIL pre_overflow: err %b ready %b count %0d want 0 1 31", load_err, bus.in_ready, word_count); end
        send(8'h9F, 1'b0);
        n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL overflow_err: got %b want 1", load_err); end
        n_checks++; if (cpu_reset !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL overflow_state: cpu_reset %b ready %b want 1 0", cpu_reset, bus.in_ready); end
        n_checks++; if (word_count !== 6'd32) begin n_fail++; $display("FAIL overflow_count: got %0d want 32", word_count); end
        read_addr = 8'd31; #1;
        n_checks++; if (instruction !== 8'h9F) begin n_fail++; $display("FAIL overflow_last_byte: got %h want 9f", instruction); end
    endtask

    task automatic test_reset_mid_load;
        start_load();
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL restart_from_err: err %b want 0", load_err); end
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        reset          = 1'b1;
        bus.load_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h44;
        tick();
        reset          = 1'b0;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        n_checks++; if (bus.in_ready !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL abort_state: ready %b cpu_reset %b want 0 1", bus.in_ready, cpu_reset); end
        n_checks++; if (word_count !== 6'd0 || load_err !== 1'b0) begin n_fail++; $display("FAIL abort_counts: count %0d err %b want 0 0", word_count, load_err); end
        read_addr = 8'd0; #1;
        n_checks++; if (instruction !== 8'h11) begin n_fail++; $display("FAIL abort_keep0: got %h want 11", instruction); end
        read_addr = 8'd2; #1;
        n_checks++; if (instruction !== 8'h33) begin n_fail++; $display("FAIL abort_keep2: got %h want 33", instruction); end
        read_addr = 8'd3; #1;
        n_checks++; if (instruction !== 8'h83) begin n_fail++; $display("FAIL reset_blocks_write: got %h want 83", instruction); end
        tick();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_beats_start: ready %b want 0", bus.in_ready); end
    endtask

    task automatic test_back_to_back;
        start_load();
        send(8'h12, 1'b0);
        send(8'h34, 1'b1);
`ifdef PROG_LOADER_CHECKSUM_EN
        send(8'h46, 1'b0);
`endif
        n_checks++; if (cpu_reset !== 1'b0 || word_count !== 6'd2) begin n_fail++; $display("FAIL short_run: cpu_reset %b count %0d want 0 2", cpu_reset, word_count); end
        bus.load_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h99;
        bus.in_last    = 1'b1;
        tick();
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_last    = 1'b0;
        n_checks++; if (word_count !== 6'd0 || cpu_reset !== 1'b1 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL restart_in_run: count %0d cpu_reset %b ready %b want 0 1 1", word_count, cpu_reset, bus.in_ready); end
        read_addr = 8'd0; #1;
        n_checks++; if (instruction !== 8'h12) begin n_fail++; $display("FAIL restart_keeps_mem: got %h want 12", instruction); end
        send(8'h56, 1'b0);
        bus.load_start = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'h77;
        tick();
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        n_checks++; if (word_count !== 6'd0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL restart_in_load: count %0d ready %b want 0 1", word_count, bus.in_ready); end
        read_addr = 8'd0; #1;
        n_checks++; if (instruction !== 8'h56) begin n_fail++; $display("FAIL discard_addr0: got %h want 56", instruction); end
        read_addr = 8'd1; #1;
        n_checks++; if (instruction !== 8'h34) begin n_fail++; $display("FAIL discard_addr1: got %h want 34", instruction); end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        start_load();
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        n_checks++; if (cpu_reset !== 1'b1 || bus.in_ready !== 1'b1 || word_count !== 6'd2) begin n_fail++; $display("FAIL csum_wait: cpu_reset %b ready %b count %0d want 1 1 2", cpu_reset, bus.in_ready, word_count); end
        send(8'h03, 1'b0);
        n_checks++; if (cpu_reset !== 1'b0 || load_err !== 1'b0 || word_count !== 6'd2) begin n_fail++; $display("FAIL csum_match: cpu_reset %b err %b count %0d want 0 0 2", cpu_reset, load_err, word_count); end
        start_load();
        send(8'h01, 1'b0);
        send(8'h02, 1'b1);
        send(8'h04, 1'b0);
        n_checks++; if (load_err !== 1'b1 || cpu_reset !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL csum_mismatch: err %b cpu_reset %b ready %b want 1 1 0", load_err, cpu_reset, bus.in_ready); end
    endtask
`endif

    initial begin
        reset          = 1'b1;
        read_addr      = 8'd0;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.in_last    = 1'b0;
        test_reset();
        test_basic_load();
        test_overflow();
        test_reset_mid_load();
        test_back_to_back();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
